// File: rtl/cic_interp_param.sv
// CIC interpolator with run-time power-of-two ratio, strobe-driven pipeline,
// half-up rounding, output saturation with sticky flag and flush on rate change.
module cic_interp_param #(
  parameter int N_STAGES      = 3,
  parameter int RATE_LOG2_MAX = 4,
  parameter int IN_W          = 16,
  parameter int OUT_W         = 16,
  parameter int RATE_W        = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic [RATE_W-1:0]       rate_log2,
  input  logic                    sat_clr,
  input  logic signed [IN_W-1:0]  filter_in,
  output logic signed [OUT_W-1:0] filter_out,
  output logic                    ce_out,
  output logic                    sat_flag
);

  localparam int W    = IN_W + N_STAGES * RATE_LOG2_MAX;
  localparam int K_W  = (RATE_LOG2_MAX > 0) ? $clog2(RATE_LOG2_MAX + 1) : 1;
  localparam int PH_W = (RATE_LOG2_MAX > 0) ? RATE_LOG2_MAX : 1;
  localparam int S_W  = $clog2(W + 1) + 1;

  localparam logic [PH_W-1:0]  PH_ONES = '1;
  localparam logic signed [W:0] OUT_MAX = {{(W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [W:0] OUT_MIN = {{(W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic [K_W-1:0]  k_reg;
  logic [K_W-1:0]  k_req;
  logic [PH_W-1:0] phase_reg;
  logic [PH_W-1:0] phase_mask;
  logic            phase_zero;
  logic            rate_change;

  logic signed [W-1:0] comb_c    [0:N_STAGES];
  logic signed [W-1:0] delay_q   [1:N_STAGES];
  logic signed [W-1:0] integ_q   [1:N_STAGES];
  logic signed [W-1:0] stuffed;

  logic [S_W-1:0]      shift_amt;
  logic signed [W:0]   integ_ext;
  logic signed [W:0]   rnd_add;
  logic signed [W:0]   round_sum;
  logic signed [W:0]   y_shift;
  logic signed [OUT_W-1:0] sat_val;
  logic                sat_hit;

  always_comb begin
    if (int'(rate_log2) > RATE_LOG2_MAX) begin
      k_req = K_W'(RATE_LOG2_MAX);
    end else begin
      k_req = K_W'(rate_log2);
    end
  end

  assign phase_mask  = ~(PH_ONES << k_reg);
  assign phase_zero  = (phase_reg == '0);
  // Reset gates the strobe so upstream never sees a capture while held in reset.
  assign ce_out      = clk_enable & reset & phase_zero;
  assign rate_change = ce_out & (k_req != k_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_reg     <= '0;
      phase_reg <= '0;
    end else if (clk_enable) begin
      if (rate_change) begin
        k_reg     <= k_req;
        phase_reg <= (k_req == '0) ? '0 : PH_W'(1);
      end else begin
        phase_reg <= (phase_reg + PH_W'(1)) & phase_mask;
      end
    end
  end

  assign comb_c[0] = W'(filter_in);

  genvar gi;
  generate
    for (gi = 1; gi <= N_STAGES; gi++) begin : g_comb
      logic signed [W-1:0] d_reg;
      assign comb_c[gi]  = comb_c[gi-1] - d_reg;
      assign delay_q[gi] = d_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          d_reg <= '0;
        end else if (rate_change) begin
          d_reg <= '0;
        end else if (ce_out) begin
          d_reg <= comb_c[gi-1];
        end
      end
    end
  endgenerate

  assign stuffed = phase_zero ? comb_c[N_STAGES] : '0;

  generate
    for (gi = 1; gi <= N_STAGES; gi++) begin : g_integ
      logic signed [W-1:0] i_reg;
      logic signed [W-1:0] i_in;
      // Each stage adds the previous stage's old value, giving one enable of delay per stage.
      if (gi == 1) begin : g_first
        assign i_in = stuffed;
      end else begin : g_rest
        assign i_in = integ_q[gi-1];
      end
      assign integ_q[gi] = i_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          i_reg <= '0;
        end else if (clk_enable) begin
          if (rate_change) begin
            i_reg <= '0;
          end else begin
            i_reg <= i_reg + i_in;
          end
        end
      end
    end
  endgenerate

  // Gain is R^(N-1) times the input width difference; strip it with round half-up.
  always_comb begin
    shift_amt = S_W'(N_STAGES - 1) * S_W'(k_reg) + S_W'(IN_W - OUT_W);
    integ_ext = {integ_q[N_STAGES][W-1], integ_q[N_STAGES]};
    rnd_add   = '0;
    if (shift_amt != '0) begin
      rnd_add = (W + 1)'(1) << (shift_amt - S_W'(1));
    end
    round_sum = integ_ext + rnd_add;
    y_shift   = round_sum >>> shift_amt;
    sat_hit   = 1'b0;
    sat_val   = y_shift[OUT_W-1:0];
    if (y_shift > OUT_MAX) begin
      sat_val = OUT_MAX[OUT_W-1:0];
      sat_hit = 1'b1;
    end else if (y_shift < OUT_MIN) begin
      sat_val = OUT_MIN[OUT_W-1:0];
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter_out <= '0;
      sat_flag   <= 1'b0;
    end else begin
      if (clk_enable) begin
        filter_out <= rate_change ? '0 : sat_val;
      end
      if (clk_enable && !rate_change && sat_hit) begin
        sat_flag <= 1'b1;
      end else if (sat_clr) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_interp_param.sv
// Scoreboard bench for cic_interp_param: convolution reference model feeds an
// expectation queue that a free-running monitor drains on every enable edge.
module tb_cic_interp_param;
  localparam int N    = 3;
  localparam int KMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clk_enable, sat_clr;
  logic [2:0] rate_log2;
  logic signed [15:0] in_a;
  logic signed [17:0] in_b;
  logic signed [15:0] out_a, out_b;
  logic ce_a, ce_b, sat_a, sat_b;

  cic_interp_param #(.N_STAGES(3), .RATE_LOG2_MAX(4), .IN_W(16), .OUT_W(16), .RATE_W(3)) dut_a (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .rate_log2(rate_log2),
    .sat_clr(sat_clr), .filter_in(in_a), .filter_out(out_a), .ce_out(ce_a), .sat_flag(sat_a));

  cic_interp_param #(.N_STAGES(3), .RATE_LOG2_MAX(4), .IN_W(18), .OUT_W(16), .RATE_W(3)) dut_b (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .rate_log2(rate_log2),
    .sat_clr(sat_clr), .filter_in(in_b), .filter_out(out_b), .ce_out(ce_b), .sat_flag(sat_b));

  typedef struct { longint out; bit ce; bit sat; } exp_t;

  int total = 0;
  int bad   = 0;
  bit sel   = 1'b0;
  exp_t   exp_q[$];
  longint out_log[$];

  // Reference model: zero-stuffed input history convolved with the CIC kernel.
  int     k_m, ph_m;
  bit     sat_m;
  longint hist[$];
  longint h[$];

  int imp_exp[17] = '{0, 0, 0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0, 0, 0, 0};

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_h();
    longint t[$];
    int r;
    r = 1 << k_m;
    h.delete();
    h.push_back(1);
    repeat (N) begin
      t.delete();
      for (int i = 0; i < h.size() + r - 1; i++) begin
        longint acc;
        acc = 0;
        for (int j = 0; j < r; j++)
          if (i - j >= 0 && i - j < h.size()) acc += h[i-j];
        t.push_back(acc);
      end
      h = t;
    end
  endtask

  task automatic model_reset();
    k_m = 0; ph_m = 0; sat_m = 1'b0;
    hist.delete();
    set_h();
  endtask

  task automatic model_enable(input longint x, input int rate, input bit clr, output exp_t e);
    int kr, s, j;
    longint y, y2;
    bit clip;
    e.ce = (ph_m == 0);
    kr = (rate > KMAX) ? KMAX : rate;
    if (e.ce && kr != k_m) begin
      k_m = kr;
      set_h();
      ph_m = (k_m == 0) ? 0 : 1;
      hist.delete();
      if (clr) sat_m = 1'b0;
      e.out = 0;
      e.sat = sat_m;
      return;
    end
    hist.push_back(e.ce ? x : 0);
    ph_m = (ph_m + 1) % (1 << k_m);
    j = hist.size() - 1;
    y = 0;
    for (int m = 0; m < h.size(); m++)
      if (j - N - m >= 0) y += h[m] * hist[j-N-m];
    s = (N - 1) * k_m + (sel ? 2 : 0);
    y2 = (s > 0) ? ((y + (longint'(1) << (s - 1))) >>> s) : y;
    clip = 1'b0;
    if (y2 > 32767) begin y2 = 32767; clip = 1'b1; end
    else if (y2 < -32768) begin y2 = -32768; clip = 1'b1; end
    if (clip) sat_m = 1'b1;
    else if (clr) sat_m = 1'b0;
    e.out = y2;
    e.sat = sat_m;
  endtask

  task automatic drive(input bit en, input longint x, input int rate, input bit clr);
    exp_t e;
    @(negedge clk);
    clk_enable = en;
    rate_log2  = 3'(rate);
    sat_clr    = clr & en;
    in_a       = x[15:0];
    in_b       = x[17:0];
    if (en) begin
      model_enable(x, rate, clr, e);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: strobe sampled before the edge, registered outputs 1 time unit after it.
  initial begin
    bit en_s, ce_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      en_s = clk_enable && reset;
      ce_s = sel ? ce_b : ce_a;
      @(posedge clk);
      #1;
      if (en_s) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_underflow actual=empty required=entry");
        end else begin
          e = exp_q.pop_front();
          check("ce_out", longint'(ce_s), longint'(e.ce));
          check("filter_out", sel ? longint'(out_b) : longint'(out_a), e.out);
          check("sat_flag", longint'(sel ? sat_b : sat_a), longint'(e.sat));
          out_log.push_back(sel ? longint'(out_b) : longint'(out_a));
        end
      end else begin
        check("ce_idle", longint'(ce_s), 0);
      end
    end
  end

  task automatic hard_reset(input bit new_sel);
    @(negedge clk);
    clk_enable = 1'b0;
    reset = 1'b0;
    sel = new_sel;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    check("pre_reset_out_nonzero", longint'(out_a != 0), 1);
    reset = 1'b0;
    clk_enable = 1'b1;
    #1;
    check("rst_filter_out", longint'(out_a), 0);
    check("rst_sat_flag", longint'(sat_a), 0);
    check("rst_ce_out", longint'(ce_a), 0);
    model_reset();
    @(negedge clk);
    clk_enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Impulse of 16 at k=2; optional enable gap or mid-response async reset.
  task automatic run_impulse(input int gap_at, input int reset_at);
    int guard;
    guard = 0;
    drive(1, 0, 2, 0);
    while (!(k_m == 2 && ph_m == 0) && guard < 40) begin
      drive(1, 0, 2, 0);
      guard++;
    end
    check("impulse_align_guard", longint'(guard < 40), 1);
    @(posedge clk);
    #2;
    out_log.delete();
    drive(1, 16, 2, 0);
    for (int i = 1; i < 17; i++) begin
      if (i == reset_at) begin
        async_reset();
        return;
      end
      if (i == gap_at) repeat (20) drive(0, 0, 2, 0);
      drive(1, 0, 2, 0);
    end
    @(posedge clk);
    #2;
    check("impulse_len", out_log.size(), 17);
    for (int i = 0; i < 17 && i < out_log.size(); i++)
      check($sformatf("impulse[%0d]", i), out_log[i], imp_exp[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int rate;
    logic signed [15:0] r16;
    reset = 1'b0; clk_enable = 1'b0; sat_clr = 1'b0; rate_log2 = '0; in_a = '0; in_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    clk_enable = 1'b1;
    #1;
    check("reset_filter_out", longint'(out_a), 0);
    check("reset_sat_flag", longint'(sat_a), 0);
    check("reset_ce_out", longint'(ce_a), 0);
    @(negedge clk);
    clk_enable = 1'b0;
    reset = 1'b1;

    run_impulse(-1, -1);

    repeat (40) drive(1, 1000, 2, 0);
    @(posedge clk); #2;
    check("dc_k2", out_log[$], 1000);
    check("dc_k2_sat", longint'(sat_a), 0);

    repeat (40) drive(1, 1000, 1, 0);
    @(posedge clk); #2;
    check("dc_k1", out_log[$], 1000);

    repeat (150) drive(1, 1000, 7, 0);
    @(posedge clk); #2;
    check("dc_k7_clamped", out_log[$], 1000);
    check("k7_model_k", k_m, KMAX);

    run_impulse(6, -1);
    run_impulse(-1, 6);
    run_impulse(-1, -1);

    rate = 2;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) rate = $urandom_range(0, 7);
      r16 = 16'($urandom);
      drive($urandom_range(0, 3) != 0, longint'(r16), rate, $urandom_range(0, 15) == 0);
    end

    hard_reset(1'b1);
    repeat (6) drive(1, 131071, 0, 0);
    @(posedge clk); #2;
    check("sat_out", out_log[$], 32767);
    check("sat_flag_set", longint'(sat_b), 1);
    repeat (6) drive(1, 0, 0, 1);
    drive(1, 0, 0, 0);
    @(posedge clk); #2;
    check("sat_flag_cleared", longint'(sat_b), 0);
    check("sat_out_zero", out_log[$], 0);

    @(negedge clk);
    clk_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_interp_param.md
# cic_interp_param

Parametrised CIC interpolator that replaces the fixed-ratio cicN stages of the interpolating chain with one block. Stage count and widths are set at build time; the interpolation ratio is selectable at run time as a power of two. It uses the chain's strobe scheme: downstream drives `clk_enable` at the output rate, and the block returns `ce_out` at the input rate to the upstream stage. It adds rounding, saturation with a sticky flag, and a clean flush on rate change.

## Interface
- `N_STAGES`, default 3: number of comb and integrator stages, range 1..6. Differential delay is fixed at 1.
- `RATE_LOG2_MAX`, default 4: largest supported log2(R).
- `IN_W`, default 16: signed input width.
- `OUT_W`, default 16: signed output width. Must satisfy OUT_W ≤ IN_W.
- `RATE_W`, default 3: width of `rate_log2`.
- `clk` input 1: sole clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `clk_enable` input 1: output-rate strobe from downstream.
- `rate_log2` input RATE_W: requested log2(R). Values above RATE_LOG2_MAX are clamped to RATE_LOG2_MAX.
- `sat_clr` input 1: synchronous clear of `sat_flag`.
- `filter_in` input IN_W: signed input sample.
- `filter_out` output OUT_W: signed output sample, registered.
- `ce_out` output 1: input-rate strobe to upstream. Combinational: `clk_enable` AND (phase == 0).
- `sat_flag` output 1: sticky; set when an output was saturated.

## Operation
- Internal width: W = IN_W + N_STAGES·RATE_LOG2_MAX. All comb and integrator arithmetic is two's-complement and wraps modulo 2^W.
- Active rate: `k` (log2 R) is held in a register. Phase counter: 0..2^k−1, advances on each `clk_enable` and wraps to 0.
- Rate latch:
  - `rate_log2` (after clamping) is sampled only on edges where `ce_out` = 1.
  - If it differs from `k`, the block does a flush on that edge:
    - `k` takes the new value;
    - phase is set to 1 (or 0 when the new k = 0);
    - all comb delay registers and integrators clear to 0;
    - `filter_out` is set to 0;
    - that input sample is discarded.
- Comb section:
  - Evaluated combinationally from `filter_in`, sign-extended to W: c_j = c_{j−1} − d_j.
  - Each delay d_j takes c_{j−1} on edges where `ce_out` = 1.
- Zero-stuffing:
  - On a `clk_enable` edge, the integrator input is c_N if phase == 0, otherwise 0.
- Integrators, pipelined, updated only on `clk_enable` edges:
  - I_1 ← I_1 + stuffed input.
  - I_j ← I_j + I_{j−1} (previous value) for j ≥ 2.
- Output stage, updated on `clk_enable` edges:
  - s = (N_STAGES−1)·k + (IN_W − OUT_W).
  - Round half-up: y = (I_N + 2^(s−1)) >>> s when s > 0; y = I_N when s = 0.
  - Saturate y to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - If clipped, set `sat_flag`.
  - The result gives unity DC gain.
- `sat_flag`: when `sat_clr` is high on the same edge as a saturation event, set has priority.
- `clk_enable` low: all state holds, `ce_out` = 0.
- k = 0 gives R = 1, i.e. pass-through (`ce_out` = `clk_enable`), delayed by the pipeline below.

## Timing
- Reset (asynchronous, active-low) clears, while held:
  - `filter_out` = 0, `sat_flag` = 0;
  - phase = 0, k = 0;
  - all comb and integrator registers = 0.
- `ce_out` is 0 while reset is active. The first `ce_out` follows the first `clk_enable` after release.
- Reset asserted mid-operation clears all state immediately. There is no partial flush.
- Input capture: `filter_in` is consumed on the edge where `ce_out` = 1. Upstream must hold it stable across that edge.
- Latency: a sample consumed at strobe edge E0 first affects `filter_out` at `clk_enable` edge E_N (N_STAGES enable edges later).
- Throughput: one input per 2^k enables, one output per enable.

## Test plan
- N=3, k=2, IN_W=OUT_W=16. Impulse of 16 followed by zeros, sampled on `ce_out` → `filter_out` = 1,3,6,10,12,12,10,6,3,1, then 0. First nonzero appears at the 3rd enable after capture. `ce_out` fires every 4th `clk_enable`.
- Same configuration, DC input 1000 → `filter_out` settles to exactly 1000 within 10 enables and stays constant; `sat_flag` = 0.
- IN_W=18, OUT_W=16, k=0. Input 131071 → rounding gives 32768, saturates to 32767, `sat_flag` = 1. Apply `sat_clr` with input 0 → `sat_flag` returns to 0 and `filter_out` = 0 on the following enable.
- Rate change: change `rate_log2` from 2 to 1 mid-stream with DC 1000.
  - Flush edge: `filter_out` = 0 and the sample is dropped.
  - Afterwards: `ce_out` every 2nd enable, output resettles to 1000.
  - `rate_log2` = 7 with RATE_LOG2_MAX = 4 behaves as k = 4.
- `clk_enable` gated low for 20 cycles mid-impulse-response → outputs resume with no skipped or repeated values; `ce_out` stays 0 while gated.
- Assert `reset` asynchronously between clock edges during operation → `filter_out`, `sat_flag`, and `ce_out` go to 0 before the next edge. After release, the impulse test repeats identically.
